// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: launches one byte per frame, o_Tx_DV one cycle after push into an idle, empty queue.
// Launch waits for i_Tx_Active=0 and i_Tx_Done; a push into a full queue with no same-cycle pop is dropped and sets o_Overflow.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Empty,
  output logic              o_Full,
  output logic              o_Overflow,
  output logic              o_Busy
);

  typedef enum logic {IDLE, WAIT_DONE} state_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              pop;
  logic              push;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    pop        = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0 && !i_Tx_Active) begin
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_q[rd_q];
          rd_d      = rd_q + ADDR_W'(1);
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Transmitter busy is deliberately ignored here; only the done pulse ends the frame.
        if (i_Tx_Done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    push = i_Wr_DV && (count_q != FULL_CNT || pop);
    if (push) begin
      mem_d[wr_q] = i_Wr_Byte;
      wr_d        = wr_q + ADDR_W'(1);
    end else if (i_Wr_DV) begin
      overflow_d = 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge i_Clock) begin
    mem_q <= mem_d;
  end

  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Count    = count_q;
  assign o_Empty    = (count_q == '0);
  assign o_Full     = (count_q == FULL_CNT);
  assign o_Overflow = overflow_q;
  assign o_Busy     = (state_q != IDLE);

endmodule
